revelar_casillas: RTL and testbench

REVELAR_CASILLAS -- requirements
Module: revelar_casillas

---
 rtl/revelar_casillas.sv | 255 +++++++++++++++++++++++++
 tb/tb_revelar_casillas.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/revelar_casillas.sv
// Minesweeper reveal engine: accepts reveal/flag commands, reads board cells and
// flood-fills zero-count regions through a 64-entry address FIFO.

module revelar_casillas_chk (
  input logic clk,
  input logic reset,
  input logic push,
  input logic full
);

  q_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full));

endmodule

module revelar_casillas #(
  parameter int CELL_W = 9
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_flag,
  input  logic [2:0]        cmd_row,
  input  logic [2:0]        cmd_col,
  output logic              rd_en,
  output logic [5:0]        rd_addr,
  input  logic [CELL_W-1:0] rd_data,
  input  logic [6:0]        bomb_total,
  output logic [63:0]       revealed,
  output logic [63:0]       flagged,
  output logic [6:0]        revealed_count,
  output logic              busy,
  output logic              lost,
  output logic              won
);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    RD_CMD  = 4'd1,
    CHK_CMD = 4'd2,
    POP     = 4'd3,
    RD_Q    = 4'd4,
    CHK_Q   = 4'd5,
    NEIGH   = 4'd6,
    LOST    = 4'd7,
    WON     = 4'd8
  } state_t;

  state_t      state_r, state_s;
  logic [63:0] revealed_r, flagged_r;
  logic [6:0]  count_r;
  logic [5:0]  q_mem_r [64];
  logic [6:0]  wr_ptr_r, rd_ptr_r;
  logic [2:0]  nb_idx_r;
  logic        ready_r, busy_r, lost_r, won_r, rd_en_r;
  logic [5:0]  rd_addr_r;

  logic        ready_s, busy_s, lost_s, won_s, rd_en_s;
  logic [5:0]  rd_addr_s;
  logic [5:0]  cmd_addr_s, q_head_s, nb_addr_s, reveal_addr_s;
  logic        cell_bomb_s, cell_zero_s, q_empty_s, q_full_s;
  logic [6:0]  count_inc_s, win_target_s;
  logic [3:0]  dr_s, dc_s, nb_row_s, nb_col_s;
  logic        nb_ok_s, flag_tgl_s, reveal_s, push_s, pop_s;
  logic        unused_s;

  assign cmd_addr_s   = {cmd_row, cmd_col};
  assign cell_bomb_s  = rd_data[8];
  assign cell_zero_s  = (rd_data[3:0] == 4'd0);
  assign unused_s     = ^{rd_data[7:4], rd_data[CELL_W-1:8]};
  assign count_inc_s  = count_r + 7'd1;
  assign win_target_s = 7'd64 - bomb_total;
  assign q_empty_s    = (wr_ptr_r == rd_ptr_r);
  assign q_full_s     = ((wr_ptr_r - rd_ptr_r) == 7'd64);
  assign q_head_s     = q_mem_r[rd_ptr_r[5:0]];

  // The current cell is whatever address was last read; out-of-range rows/cols set bit 3.
  assign nb_row_s  = {1'b0, rd_addr_r[5:3]} + dr_s;
  assign nb_col_s  = {1'b0, rd_addr_r[2:0]} + dc_s;
  assign nb_ok_s   = !nb_row_s[3] && !nb_col_s[3];
  assign nb_addr_s = {nb_row_s[2:0], nb_col_s[2:0]};

  // Neighbour offset for the current visit: N, NE, E, SE, S, SW, W, NW
  always_comb begin
    dr_s = 4'd0;
    dc_s = 4'd0;
    case (nb_idx_r)
      3'd0: begin dr_s = 4'hF; dc_s = 4'h0; end
      3'd1: begin dr_s = 4'hF; dc_s = 4'h1; end
      3'd2: begin dr_s = 4'h0; dc_s = 4'h1; end
      3'd3: begin dr_s = 4'h1; dc_s = 4'h1; end
      3'd4: begin dr_s = 4'h1; dc_s = 4'h0; end
      3'd5: begin dr_s = 4'h1; dc_s = 4'hF; end
      3'd6: begin dr_s = 4'h0; dc_s = 4'hF; end
      3'd7: begin dr_s = 4'hF; dc_s = 4'hF; end
      default: begin dr_s = 4'h0; dc_s = 4'h0; end
    endcase
  end

  // State register and registered Moore outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      ready_r   <= 1'b1;
      busy_r    <= 1'b0;
      lost_r    <= 1'b0;
      won_r     <= 1'b0;
      rd_en_r   <= 1'b0;
      rd_addr_r <= 6'd0;
    end else begin
      state_r   <= state_s;
      ready_r   <= ready_s;
      busy_r    <= busy_s;
      lost_r    <= lost_s;
      won_r     <= won_s;
      rd_en_r   <= rd_en_s;
      rd_addr_r <= rd_addr_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid && !cmd_flag && !revealed_r[cmd_addr_s] && !flagged_r[cmd_addr_s]) begin
          state_s = RD_CMD;
        end else begin
          state_s = IDLE;
        end
      end
      RD_CMD: state_s = CHK_CMD;
      CHK_CMD: begin
        if (cell_bomb_s) begin
          state_s = LOST;
        end else if (cell_zero_s) begin
          state_s = POP;
        end else if (count_inc_s == win_target_s) begin
          state_s = WON;
        end else begin
          state_s = IDLE;
        end
      end
      POP: begin
        if (!q_empty_s) begin
          state_s = RD_Q;
        end else if (count_r == win_target_s) begin
          state_s = WON;
        end else begin
          state_s = IDLE;
        end
      end
      RD_Q:  state_s = CHK_Q;
      CHK_Q: state_s = cell_zero_s ? NEIGH : POP;
      NEIGH: state_s = (nb_idx_r == 3'd7) ? POP : NEIGH;
      LOST:  state_s = LOST;
      WON:   state_s = WON;
      default: state_s = IDLE;
    endcase
  end

  // Output and datapath control decode
  always_comb begin
    ready_s = (state_s == IDLE);
    busy_s  = !((state_s == IDLE) || (state_s == LOST) || (state_s == WON));
    lost_s  = (state_s == LOST);
    won_s   = (state_s == WON);
    rd_en_s = (state_s == RD_CMD) || (state_s == RD_Q);
    if (state_s == RD_CMD) begin
      rd_addr_s = cmd_addr_s;
    end else if (state_s == RD_Q) begin
      rd_addr_s = q_head_s;
    end else begin
      rd_addr_s = rd_addr_r;
    end
    flag_tgl_s    = (state_r == IDLE) && cmd_valid && cmd_flag && !revealed_r[cmd_addr_s];
    reveal_s      = 1'b0;
    push_s        = 1'b0;
    pop_s         = 1'b0;
    reveal_addr_s = rd_addr_r;
    case (state_r)
      CHK_CMD: begin
        reveal_s = 1'b1;
        push_s   = !cell_bomb_s && cell_zero_s;
      end
      POP: pop_s = !q_empty_s;
      NEIGH: begin
        reveal_addr_s = nb_addr_s;
        if (nb_ok_s && !revealed_r[nb_addr_s] && !flagged_r[nb_addr_s]) begin
          reveal_s = 1'b1;
          push_s   = 1'b1;
        end else begin
          reveal_s = 1'b0;
          push_s   = 1'b0;
        end
      end
      default: begin
        reveal_s = 1'b0;
        push_s   = 1'b0;
      end
    endcase
  end

  // Board masks, reveal counter, queue pointers and neighbour index
  always_ff @(posedge clk) begin
    if (reset) begin
      revealed_r <= 64'd0;
      flagged_r  <= 64'd0;
      count_r    <= 7'd0;
      wr_ptr_r   <= 7'd0;
      rd_ptr_r   <= 7'd0;
      nb_idx_r   <= 3'd0;
    end else begin
      if (flag_tgl_s) begin
        flagged_r[cmd_addr_s] <= ~flagged_r[cmd_addr_s];
      end
      if (reveal_s) begin
        revealed_r[reveal_addr_s] <= 1'b1;
        count_r                   <= count_inc_s;
      end
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + 7'd1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 7'd1;
      end
      nb_idx_r <= (state_r == NEIGH) ? (nb_idx_r + 3'd1) : 3'd0;
    end
  end

  // Queue storage; pointers alone define its contents, so no reset needed here
  always_ff @(posedge clk) begin
    if (push_s) begin
      q_mem_r[wr_ptr_r[5:0]] <= reveal_addr_s;
    end
  end

  revelar_casillas_chk u_chk (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .full  (q_full_s)
  );

  assign cmd_ready      = ready_r;
  assign busy           = busy_r;
  assign lost           = lost_r;
  assign won            = won_r;
  assign rd_en          = rd_en_r;
  assign rd_addr        = rd_addr_r;
  assign revealed       = revealed_r;
  assign flagged        = flagged_r;
  assign revealed_count = count_r;

endmodule

// File: tb/tb_revelar_casillas.sv
// Bench for revelar_casillas: directed table on a fixed board, hand-timed corner
// sequences, and random games checked against a queue-based game model.

module tb_revelar_casillas;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_flag = 1'b0;
  logic [2:0]  cmd_row = 3'd0;
  logic [2:0]  cmd_col = 3'd0;
  logic        rd_en;
  logic [5:0]  rd_addr;
  logic [8:0]  rd_data = 9'd0;
  logic [6:0]  bomb_total = 7'd0;
  logic [63:0] revealed, flagged;
  logic [6:0]  revealed_count;
  logic        busy, lost, won;

  revelar_casillas #(.CELL_W(9)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_flag(cmd_flag), .cmd_row(cmd_row), .cmd_col(cmd_col), .rd_en(rd_en),
    .rd_addr(rd_addr), .rd_data(rd_data), .bomb_total(bomb_total),
    .revealed(revealed), .flagged(flagged), .revealed_count(revealed_count),
    .busy(busy), .lost(lost), .won(won)
  );

  always #5 clk = ~clk;

  logic [8:0] board [64];
  int rd_total = 0;

  // Board memory with one cycle of read latency, plus a read-strobe counter
  always @(posedge clk) begin
    if (rd_en) begin
      rd_data  <= board[rd_addr];
      rd_total <= rd_total + 1;
    end
  end

  int n_cmp = 0;
  int n_fail = 0;

  logic [63:0] m_bombs, m_rev, m_flag;
  int          m_cnt, m_reads, m_total;
  bit          m_lost, m_won;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic int ncount(input logic [63:0] b, input int a);
    int n = 0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++) begin
        int r = a / 8 + dr;
        int c = a % 8 + dc;
        if (!(dr == 0 && dc == 0) && r >= 0 && r < 8 && c >= 0 && c < 8 && b[r*8+c]) n++;
      end
    return n;
  endfunction

  task automatic load_board(input logic [63:0] b);
    m_bombs = b;
    m_total = $countones(b);
    bomb_total = 7'(m_total);
    for (int i = 0; i < 64; i++) begin
      logic [3:0] junk;
      junk = 4'($urandom);
      board[i] = {b[i], junk, 4'(ncount(b, i))};
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_rev = 64'd0; m_flag = 64'd0; m_cnt = 0; m_lost = 1'b0; m_won = 1'b0;
  endtask

  // Game model: whole-command effect computed by breadth-first flood fill
  task automatic model_cmd(input bit flag, input int a);
    int q[$];
    m_reads = 0;
    if (m_lost || m_won) return;
    if (flag) begin
      if (!m_rev[a]) m_flag[a] = ~m_flag[a];
      return;
    end
    if (m_rev[a] || m_flag[a]) return;
    m_reads = 1;
    m_rev[a] = 1'b1;
    m_cnt++;
    if (m_bombs[a]) begin
      m_lost = 1'b1;
      return;
    end
    if (ncount(m_bombs, a) == 0) q.push_back(a);
    while (q.size() > 0) begin
      int p = q.pop_front();
      m_reads++;
      if (ncount(m_bombs, p) == 0)
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++) begin
            int r = p / 8 + dr;
            int c = p % 8 + dc;
            if (!(dr == 0 && dc == 0) && r >= 0 && r < 8 && c >= 0 && c < 8) begin
              int n = r * 8 + c;
              if (!m_rev[n] && !m_flag[n]) begin
                m_rev[n] = 1'b1;
                m_cnt++;
                q.push_back(n);
              end
            end
          end
    end
    if (m_cnt == 64 - m_total) m_won = 1'b1;
  endtask

  task automatic run_cmd(input bit flag, input int row, input int col, input string tag);
    int reads0 = rd_total;
    bit done = 1'b0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_flag = flag; cmd_row = 3'(row); cmd_col = 3'(col);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 2000 && !done; i++) begin
      if (cmd_ready || lost || won) done = 1'b1;
      else @(negedge clk);
    end
    n_cmp++;
    if (!done) begin
      n_fail++;
      $display("FAIL %s timeout: command never completed within 2000 cycles", tag);
    end
    model_cmd(flag, row * 8 + col);
    check({tag, " revealed"}, revealed, m_rev);
    check({tag, " flagged"}, flagged, m_flag);
    check({tag, " count"}, 64'(revealed_count), 64'(m_cnt));
    check({tag, " lost"}, 64'(lost), 64'(m_lost));
    check({tag, " won"}, 64'(won), 64'(m_won));
    check({tag, " reads"}, 64'(rd_total - reads0), 64'(m_reads));
    check({tag, " busy"}, 64'(busy), 64'd0);
  endtask

  typedef struct {
    bit do_reset; bit flag; int row; int col;
    int exp_count; bit exp_lost; bit exp_won; int idx; bit exp_rev; bit exp_flag;
  } vec_t;

  vec_t vecs [10];

  initial begin
    vecs[0] = '{1, 0, 7, 7,  1, 1, 0, 63, 1, 0};
    vecs[1] = '{1, 1, 3, 3,  0, 0, 0, 27, 0, 1};
    vecs[2] = '{0, 0, 3, 3,  0, 0, 0, 27, 0, 1};
    vecs[3] = '{0, 1, 3, 3,  0, 0, 0, 27, 0, 0};
    vecs[4] = '{0, 0, 7, 6,  1, 0, 0, 62, 1, 0};
    vecs[5] = '{0, 0, 0, 0, 63, 0, 1,  0, 1, 0};
    vecs[6] = '{1, 1, 7, 6,  0, 0, 0, 62, 0, 1};
    vecs[7] = '{0, 0, 0, 0, 62, 0, 0, 62, 0, 1};
    vecs[8] = '{0, 1, 7, 6, 62, 0, 0, 62, 0, 0};
    vecs[9] = '{0, 0, 7, 6, 63, 0, 1, 62, 1, 0};

    load_board(64'h8000_0000_0000_0000);
    do_reset();
    check("reset ready", 64'(cmd_ready), 64'd1);
    check("reset busy", 64'(busy), 64'd0);
    check("reset revealed", revealed, 64'd0);
    check("reset count", 64'(revealed_count), 64'd0);
    check("reset rd_en", 64'(rd_en), 64'd0);

    for (int i = 0; i < 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      if (vecs[i].do_reset) do_reset();
      run_cmd(vecs[i].flag, vecs[i].row, vecs[i].col, t);
      check({t, " tbl count"}, 64'(revealed_count), 64'(vecs[i].exp_count));
      check({t, " tbl lost"}, 64'(lost), 64'(vecs[i].exp_lost));
      check({t, " tbl won"}, 64'(won), 64'(vecs[i].exp_won));
      check({t, " tbl rev bit"}, 64'(revealed[vecs[i].idx]), 64'(vecs[i].exp_rev));
      check({t, " tbl flag bit"}, 64'(flagged[vecs[i].idx]), 64'(vecs[i].exp_flag));
      check({t, " tbl ready"}, 64'(cmd_ready), 64'(!(vecs[i].exp_lost || vecs[i].exp_won)));
    end

    // Numbered cell: one read, back in IDLE three cycles after acceptance
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_flag = 1'b0; cmd_row = 3'd7; cmd_col = 3'd6;
    @(negedge clk);
    cmd_valid = 1'b0;
    check("lat c1 rd_en", 64'(rd_en), 64'd1);
    check("lat c1 rd_addr", 64'(rd_addr), 64'd62);
    check("lat c1 busy", 64'(busy), 64'd1);
    @(negedge clk);
    check("lat c2 rd_en", 64'(rd_en), 64'd0);
    check("lat c2 ready", 64'(cmd_ready), 64'd0);
    @(negedge clk);
    check("lat c3 ready", 64'(cmd_ready), 64'd1);
    check("lat c3 revealed", revealed, 64'h4000_0000_0000_0000);

    // Zero cell on the right edge must not wrap into column 0 of the next row
    load_board(64'h0000_0000_0040_0020);
    do_reset();
    run_cmd(1'b0, 0, 7, "wrap");
    check("wrap mask", revealed, 64'h0000_0000_0000_C0C0);

    // Reset in the middle of neighbour visiting
    load_board(64'h8000_0000_0000_0000);
    do_reset();
    @(negedge clk);
    cmd_valid = 1'b1; cmd_flag = 1'b0; cmd_row = 3'd0; cmd_col = 3'd0;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midfill busy", 64'(busy), 64'd1);
    check("midfill partial", 64'(revealed[0]), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check("abort revealed", revealed, 64'd0);
    check("abort flagged", flagged, 64'd0);
    check("abort count", 64'(revealed_count), 64'd0);
    check("abort ready", 64'(cmd_ready), 64'd1);
    check("abort busy", 64'(busy), 64'd0);
    reset = 1'b0;

    // Random games against the model
    for (int g = 0; g < 12; g++) begin
      logic [63:0] b;
      int nb;
      b = 64'd0;
      nb = $urandom_range(1, 10);
      for (int k = 0; k < nb; k++) b[$urandom_range(0, 63)] = 1'b1;
      load_board(b);
      do_reset();
      for (int c = 0; c < 25 && !m_lost && !m_won; c++) begin
        run_cmd(($urandom_range(0, 3) == 0), $urandom_range(0, 7), $urandom_range(0, 7),
                $sformatf("g%0d c%0d", g, c));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
